regfile_wb_arbiter: RTL and testbench
=====================================

REGFILE_WB_ARBITER -- requirements
Module: regfile_wb_arbiter

Interface
REQ-001 Parameter NREQ, default 3, number of writeback requesters sharing the register-file write port.
REQ-002 Parameter XLEN, default 32, data width.
REQ-003 Parameter NREG, default 32, register count (address width REG_AW = 5).
REQ-004 The block SHALL use one clock and an asynchronous, active-high reset, named as follows.
REQ-005 clk  in  1  rising-edge clock.
REQ-006 rst  in  1  asynchronous active-high reset.
REQ-007 req_valid  in  NREQ  requester i has a write pending.
REQ-008 req_addr  in  NREQ*5  destination register per requester.
REQ-009 req_data  in  NREQ*XLEN  write data per requester.
REQ-010 req_ready  out  NREQ  one-hot grant; transfer occurs when valid&ready.
REQ-011 we3  out  1  register-file write enable.
REQ-012 a3  out  5  register-file write address.
REQ-013 wd3  out  XLEN  register-file write data.
REQ-014 sb_set  in  1  issue stage reserves a destination.
REQ-015 sb_addr  in  5  reserved destination register.
REQ-016 chk_a1, chk_a2  in  5 each  read addresses to hazard-check.
REQ-017 hazard1, hazard2  out  1 each  operand register has a pending write.

Function
REQ-018 req_ready SHALL be combinational, at most one bit high, and only for a requester with req_valid high.
REQ-019 The block SHALL never deassert req_ready[i] while req_valid[i] is held and req_ready[i] is granted in the same cycle.
REQ-020 An accepted write in cycle N SHALL appear on we3/a3/wd3 in cycle N+1 for exactly one cycle; this gives one cycle of latency and full throughput.
REQ-021 An accepted request with req_addr = 0 SHALL be consumed with we3 = 0 in cycle N+1.
REQ-022 With no accepted request in cycle N, we3 SHALL be 0 in cycle N+1, and a3/wd3 SHALL hold their previous values.
REQ-023 Scoreboard: 32-bit busy vector; sb_set with sb_addr != 0 SHALL set busy[sb_addr] at the clock edge.
REQ-024 A cycle with we3 = 1 SHALL clear busy[a3] at the end of that cycle.
REQ-025 A simultaneous set and clear of the same register SHALL leave the bit set (the new producer wins).
REQ-026 hazardK = busy[chk_aK] && chk_aK != 0; the output SHALL be combinational.
REQ-027 busy[0] SHALL always read 0.

Reset
REQ-028 rst SHALL asynchronously force we3 = 0, a3 = 0, wd3 = 0, busy = 0, and the arbitration pointer = 0.
REQ-029 A request presented during reset SHALL NOT be accepted, and req_ready SHALL be 0.
REQ-030 A write already registered when reset asserts mid-operation SHALL be discarded (we3 forced 0).

Configuration
REQ-031 With macro WB_ARB_RR_EN defined, arbitration SHALL be round-robin: the search starts at the pointer, and after a grant to i the pointer becomes (i+1) mod NREQ.
REQ-032 Without WB_ARB_RR_EN, arbitration SHALL be fixed priority, with the lowest index winning, and no pointer is implemented.

Structure
REQ-033 Package regfile_pkg SHALL hold XLEN, NREG, REG_AW and the wb_req_t struct (valid, addr, data).
REQ-034 Arbitration logic SHALL live in sub-module wb_rr_arbiter (request vector in, one-hot grant out, pointer internal).

Verification
REQ-035 After reset, drive req0 (addr 5, data 0xDEADBEEF) -> req_ready = 001 same cycle; next cycle we3 = 1, a3 = 5, wd3 = 0xDEADBEEF.
REQ-036 Hold all three requesters valid for 6 cycles with RR enabled -> grants 0,1,2,0,1,2; without the macro -> grants 0,0,0,... while req0 remains valid.
REQ-037 Drive req1 with addr 0, data 0x1234 -> req_ready[1] = 1; next cycle we3 = 0.
REQ-038 sb_set addr 7; chk_a1 = 7 -> hazard1 = 1 next cycle; write to 7 commits -> hazard1 = 0 after that cycle; set and commit of 7 in the same cycle -> hazard1 stays 1.
REQ-039 Assert rst while we3 = 1 and busy[3] = 1 -> we3, a3, wd3 and busy all 0 immediately, without waiting for a clock edge.

Source files
------------

// File: rtl/regfile_pkg.sv
// Shared widths and the writeback request record for the register-file write port.
package regfile_pkg;

    localparam int XLEN   = 32;
    localparam int NREG   = 32;
    localparam int REG_AW = 5;

    typedef struct packed {
        logic              valid;
        logic [REG_AW-1:0] addr;
        logic [XLEN-1:0]   data;
    } wb_req_t;

endpackage

// File: rtl/wb_rr_arbiter.sv
// One-hot grant over N requesters. Round-robin when WB_ARB_RR_EN is defined,
// otherwise fixed priority with the lowest index winning.
module wb_rr_arbiter #(
    parameter int N = 3
) (
    input  logic         clk,
    input  logic         rst,
    input  logic [N-1:0] req,
    output logic [N-1:0] grant
);

    localparam int PW = (N > 1) ? $clog2(N) : 1;

    logic [N-1:0] grant_s;

`ifdef WB_ARB_RR_EN
    logic [PW-1:0] ptr_r;
    logic [PW-1:0] next_ptr_s;
    logic [PW-1:0] idx_s;
    logic          found_s;

    // Search from the pointer, wrapping, and take the first pending requester.
    always_comb begin
        grant_s    = '0;
        found_s    = 1'b0;
        next_ptr_s = ptr_r;
        idx_s      = '0;
        for (int k = 0; k < N; k++) begin
            idx_s = PW'((int'(ptr_r) + k) % N);
            if (req[idx_s] && !found_s) begin
                grant_s[idx_s] = 1'b1;
                found_s        = 1'b1;
                next_ptr_s     = (idx_s == PW'(N - 1)) ? '0 : idx_s + PW'(1);
            end else begin
                grant_s = grant_s;
            end
        end
    end

    // Pointer moves one past the winner; a grant is always a transfer.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ptr_r <= '0;
        end else if (found_s) begin
            ptr_r <= next_ptr_s;
        end else begin
            ptr_r <= ptr_r;
        end
    end
`else
    logic unused_clk_s;
    assign unused_clk_s = clk;

    // Isolate the lowest set request bit.
    always_comb begin
        grant_s = req & (~req + N'(1));
    end
`endif

    // No grants while reset is held.
    always_comb begin
        if (rst) begin
            grant = '0;
        end else begin
            grant = grant_s;
        end
    end

endmodule

// File: rtl/regfile_wb_arbiter.sv
// Shares the register-file write port among NREQ writeback requesters and keeps a
// pending-write scoreboard for operand hazard checks. Optional macro: WB_ARB_RR_EN.
module regfile_wb_arbiter
    import regfile_pkg::*;
#(
    parameter int NREQ = 3,
    parameter int XLEN = regfile_pkg::XLEN,
    parameter int NREG = regfile_pkg::NREG
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic [NREQ-1:0]        req_valid,
    input  logic [NREQ*REG_AW-1:0] req_addr,
    input  logic [NREQ*XLEN-1:0]   req_data,
    output logic [NREQ-1:0]        req_ready,
    output logic                   we3,
    output logic [REG_AW-1:0]      a3,
    output logic [XLEN-1:0]        wd3,
    input  logic                   sb_set,
    input  logic [REG_AW-1:0]      sb_addr,
    input  logic [REG_AW-1:0]      chk_a1,
    input  logic [REG_AW-1:0]      chk_a2,
    output logic                   hazard1,
    output logic                   hazard2
);

    logic [NREQ-1:0] grant_s;
    wb_req_t         sel_s;
    logic [NREG-1:0] busy_r;
    logic [NREG-1:0] busy_nxt_s;

    wb_rr_arbiter #(.N(NREQ)) u_arb (
        .clk   (clk),
        .rst   (rst),
        .req   (req_valid),
        .grant (grant_s)
    );

    assign req_ready = grant_s;

    // Mux the granted requester onto a single record.
    always_comb begin
        sel_s = '0;
        for (int i = 0; i < NREQ; i++) begin
            if (grant_s[i]) begin
                sel_s.valid = 1'b1;
                sel_s.addr  = req_addr[i*REG_AW +: REG_AW];
                sel_s.data  = req_data[i*XLEN +: XLEN];
            end else begin
                sel_s = sel_s;
            end
        end
    end

    // Write port register; x0 writes are consumed without a write enable.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            we3 <= 1'b0;
            a3  <= '0;
            wd3 <= '0;
        end else if (sel_s.valid && (sel_s.addr != '0)) begin
            we3 <= 1'b1;
            a3  <= sel_s.addr;
            wd3 <= sel_s.data;
        end else begin
            we3 <= 1'b0;
        end
    end

    // Set is applied after clear so a new producer wins on collision.
    always_comb begin
        busy_nxt_s = busy_r;
        if (we3) begin
            busy_nxt_s[a3] = 1'b0;
        end else begin
            busy_nxt_s = busy_nxt_s;
        end
        if (sb_set && (sb_addr != '0)) begin
            busy_nxt_s[sb_addr] = 1'b1;
        end else begin
            busy_nxt_s = busy_nxt_s;
        end
        busy_nxt_s[0] = 1'b0;
    end

    // Scoreboard register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            busy_r <= '0;
        end else begin
            busy_r <= busy_nxt_s;
        end
    end

    assign hazard1 = busy_r[chk_a1] && (chk_a1 != '0);
    assign hazard2 = busy_r[chk_a2] && (chk_a2 != '0);

endmodule

// File: tb/tb_regfile_wb_arbiter.sv
// Directed + randomized bench for regfile_wb_arbiter against a behavioural model.
module tb_regfile_wb_arbiter;

    logic        clk = 1'b0;
    logic        rst;
    logic [2:0]  req_valid;
    logic [14:0] req_addr;
    logic [95:0] req_data;
    logic [2:0]  req_ready;
    logic        we3;
    logic [4:0]  a3;
    logic [31:0] wd3;
    logic        sb_set;
    logic [4:0]  sb_addr;
    logic [4:0]  chk_a1;
    logic [4:0]  chk_a2;
    logic        hazard1;
    logic        hazard2;

    int checks = 0;
    int errors = 0;

    // behavioural model state
    logic [31:0] m_busy;
    logic        m_we3;
    logic [4:0]  m_a3;
    logic [31:0] m_wd3;
    int          m_ptr;
    logic [2:0]  obs_ready;
    logic        obs_h1;

    regfile_wb_arbiter dut (
        .clk(clk), .rst(rst), .req_valid(req_valid), .req_addr(req_addr),
        .req_data(req_data), .req_ready(req_ready), .we3(we3), .a3(a3), .wd3(wd3),
        .sb_set(sb_set), .sb_addr(sb_addr), .chk_a1(chk_a1), .chk_a2(chk_a2),
        .hazard1(hazard1), .hazard2(hazard2)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic int arb_pick(input logic [2:0] v, input int p);
`ifdef WB_ARB_RR_EN
        for (int k = 0; k < 3; k++) if (v[(p + k) % 3]) return (p + k) % 3;
`else
        for (int i = 0; i < 3; i++) if (v[i]) return i;
`endif
        return -1;
    endfunction

    task automatic set_req(input int i, input logic v, input logic [4:0] a, input logic [31:0] d);
        req_valid[i]       = v;
        req_addr[i*5 +: 5] = a;
        req_data[i*32 +: 32] = d;
    endtask

    task automatic model_reset();
        m_busy = '0; m_we3 = 1'b0; m_a3 = '0; m_wd3 = '0; m_ptr = 0;
    endtask

    // One clock cycle: combinational checks before the edge, registered checks after.
    task automatic step();
        int g;
        logic [4:0] ad;
        g = arb_pick(req_valid, m_ptr);
        #1;
        obs_ready = req_ready;
        obs_h1    = hazard1;
        check("req_ready", 64'(req_ready), (g >= 0) ? (64'(1) << g) : 64'(0));
        check("hazard1", 64'(hazard1), 64'(m_busy[chk_a1] && (chk_a1 != 5'd0)));
        check("hazard2", 64'(hazard2), 64'(m_busy[chk_a2] && (chk_a2 != 5'd0)));
        @(posedge clk);
        if (m_we3) m_busy[m_a3] = 1'b0;
        if (sb_set && (sb_addr != 5'd0)) m_busy[sb_addr] = 1'b1;
        if (g >= 0) begin
            ad = req_addr[g*5 +: 5];
            if (ad != 5'd0) begin
                m_we3 = 1'b1; m_a3 = ad; m_wd3 = req_data[g*32 +: 32];
            end else begin
                m_we3 = 1'b0;
            end
            m_ptr = (g + 1) % 3;
        end else begin
            m_we3 = 1'b0;
        end
        #1;
        check("we3", 64'(we3), 64'(m_we3));
        check("a3", 64'(a3), 64'(m_a3));
        check("wd3", 64'(wd3), 64'(m_wd3));
    endtask

    task automatic idle();
        req_valid = '0; sb_set = 1'b0;
    endtask

    initial begin
        rst = 1'b1;
        req_valid = 3'b111; req_addr = {5'd3, 5'd2, 5'd1}; req_data = {3{32'hA5A5_0001}};
        sb_set = 1'b1; sb_addr = 5'd4; chk_a1 = 5'd4; chk_a2 = 5'd2;
        model_reset();

        // reset state, with requests and a reservation presented during reset
        @(posedge clk); #1;
        check("rst_ready", 64'(req_ready), 64'(0));
        check("rst_we3", 64'(we3), 64'(0));
        check("rst_a3", 64'(a3), 64'(0));
        check("rst_wd3", 64'(wd3), 64'(0));
        check("rst_haz1", 64'(hazard1), 64'(0));
        rst = 1'b0;
        idle();
        step();

        // all three valid for six cycles
        for (int i = 0; i < 3; i++) set_req(i, 1'b1, 5'(10 + i), 32'(100 + i));
        for (int k = 0; k < 6; k++) begin
            step();
`ifdef WB_ARB_RR_EN
            check("rr_grant", 64'(obs_ready), 64'(1) << (k % 3));
`else
            check("fp_grant", 64'(obs_ready), 64'(1));
`endif
        end

        // single write from requester 0
        idle();
        set_req(0, 1'b1, 5'd5, 32'hDEADBEEF);
        step();
        check("wr_ready", 64'(obs_ready), 64'(3'b001));
        check("wr_we3", 64'(we3), 64'(1));
        check("wr_a3", 64'(a3), 64'(5));
        check("wr_wd3", 64'(wd3), 64'(32'hDEADBEEF));

        // x0 write is consumed without a write enable
        idle();
        set_req(1, 1'b1, 5'd0, 32'h1234);
        step();
        check("x0_ready", 64'(obs_ready), 64'(3'b010));
        check("x0_we3", 64'(we3), 64'(0));
        idle();
        step();

        // scoreboard set, commit clear, and collision
        sb_set = 1'b1; sb_addr = 5'd7; chk_a1 = 5'd7; chk_a2 = 5'd0;
        step();
        sb_set = 1'b0;
        step();
        check("sb_set_h1", 64'(obs_h1), 64'(1));
        set_req(2, 1'b1, 5'd7, 32'h7777);
        step();
        idle();
        step();
        step();
        check("sb_clr_h1", 64'(obs_h1), 64'(0));
        set_req(0, 1'b1, 5'd7, 32'h7070);
        step();
        idle();
        sb_set = 1'b1; sb_addr = 5'd7;
        step();
        sb_set = 1'b0;
        step();
        check("sb_collide_h1", 64'(obs_h1), 64'(1));

        // randomized traffic
        for (int n = 0; n < 300; n++) begin
            for (int i = 0; i < 3; i++)
                set_req(i, 1'($urandom_range(0, 1)), 5'($urandom_range(0, 7)), $urandom);
            sb_set  = 1'($urandom_range(0, 1));
            sb_addr = 5'($urandom_range(0, 7));
            chk_a1  = 5'($urandom_range(0, 7));
            chk_a2  = 5'($urandom_range(0, 7));
            step();
        end

        // asynchronous reset while a write and a reservation are live
        idle();
        step();
        sb_set = 1'b1; sb_addr = 5'd3; chk_a1 = 5'd3; chk_a2 = 5'd9;
        set_req(1, 1'b1, 5'd9, 32'hCAFE_F00D);
        step();
        check("pre_rst_we3", 64'(we3), 64'(1));
        idle();
        rst = 1'b1;
        #1;
        check("arst_we3", 64'(we3), 64'(0));
        check("arst_a3", 64'(a3), 64'(0));
        check("arst_wd3", 64'(wd3), 64'(0));
        check("arst_haz1", 64'(hazard1), 64'(0));
        check("arst_ready", 64'(req_ready), 64'(0));
        @(posedge clk); #1;
        rst = 1'b0;
        model_reset();
        step();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
